// File: rtl/result_arb_pkg.sv
// result_arb_pkg: shared constants, lock state type and pointer-wrap helper for result_bus_arbiter
package result_arb_pkg;
    localparam int SEL_W   = 4;
    localparam int MAX_REQ = 16;
    typedef enum logic {UNLOCKED, LOCKED} lock_state_t;
    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] i, input int n);
        return (int'(i) == n - 1) ? '0 : i + SEL_W'(1);
    endfunction
endpackage

// File: rtl/result_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick, first valid index at or after ptr with wrap
module rr_pick
    import result_arb_pkg::*;
#(
    parameter int NUM_REQ = 16
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any,
    output logic [SEL_W-1:0]   win
);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [SEL_W:0]       sum;
    always_comb begin
        dbl = {req_valid, req_valid} >> ptr;
        rot = dbl[NUM_REQ-1:0];
        any = |rot;
        sum = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (rot[k]) sum = {1'b0, ptr} + (SEL_W+1)'(k);
        win = (sum >= (SEL_W+1)'(NUM_REQ)) ? SEL_W'(sum - (SEL_W+1)'(NUM_REQ)) : sum[SEL_W-1:0];
    end
endmodule

// File: rtl/result_bus_arbiter.sv
// result_bus_arbiter: round-robin result bus arbiter with registered output stage; RESULT_ARB_LOCK_EN adds grant locking
module result_bus_arbiter
    import result_arb_pkg::*;
#(
    parameter int NUM_REQ = 16,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
`ifdef RESULT_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        req_lock,
`endif
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [SEL_W-1:0]          out_src,
    input  logic                      out_ready
);
    logic [SEL_W-1:0]   ptr;
    logic [SEL_W-1:0]   win;
    logic               any;
    logic               load_en;
    logic               accept;
    logic [NUM_REQ-1:0] cand;
    logic [DATA_W-1:0]  mux_in [MAX_REQ];
    for (genvar g = 0; g < MAX_REQ; g++) begin : g_mux
        if (g < NUM_REQ) begin : g_used
            assign mux_in[g] = req_data[g*DATA_W +: DATA_W];
        end else begin : g_tie
            assign mux_in[g] = '0;
        end
    end
`ifdef RESULT_ARB_LOCK_EN
    lock_state_t      state;
    logic [SEL_W-1:0] lock_id;
    // while locked, only the lock holder is visible to the picker
    assign cand = (state == LOCKED) ? (req_valid & (NUM_REQ'(1) << lock_id)) : req_valid;
`else
    assign cand = req_valid;
`endif
    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_valid(cand),
        .ptr      (ptr),
        .any      (any),
        .win      (win)
    );
    assign load_en   = !out_valid || out_ready;
    assign accept    = load_en && any && !rst;
    assign req_ready = accept ? (NUM_REQ'(1) << win) : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
`ifdef RESULT_ARB_LOCK_EN
            state     <= UNLOCKED;
            lock_id   <= '0;
`endif
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= mux_in[win];
                out_src   <= win;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
`ifdef RESULT_ARB_LOCK_EN
            if (accept && state == UNLOCKED && req_lock[win]) begin
                state   <= LOCKED;
                lock_id <= win;
            end else if (accept && state == LOCKED && !req_lock[win]) begin
                state <= UNLOCKED;
                ptr   <= wrap_inc(lock_id, NUM_REQ);
            end else if (accept && state == UNLOCKED) begin
                ptr <= wrap_inc(win, NUM_REQ);
            end
`else
            if (accept) ptr <= wrap_inc(win, NUM_REQ);
`endif
        end
    end
endmodule

// File: tb/tb_result_bus_arbiter.sv
// tb_result_bus_arbiter: directed bench with a cycle model of the arbiter rules and literal grant checks
module tb_result_bus_arbiter;
    localparam int N = 4;
    localparam int W = 32;
    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_lock = '0;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [3:0]     out_src;
    logic           out_ready = 1'b1;
    int n_tests = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    int       m_ptr = 0;
    bit       m_ov = 1'b0;
    bit [31:0] m_od = '0;
    int       m_os = 0;
    bit       m_locked = 1'b0;
    int       m_lid = 0;

    result_bus_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_data (req_data),
`ifdef RESULT_ARB_LOCK_EN
        .req_lock (req_lock),
`endif
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_src  (out_src),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // scan order ptr, ptr+1, ... with wrap; a lock restricts eligibility to the holder
    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (m_locked && j != m_lid) continue;
            if (req_valid[j]) return j;
        end
        return -1;
    endfunction

    function automatic int exp_ready();
        int w;
        w = pick();
        if (rst || (m_ov && !out_ready) || w < 0) return 0;
        return 1 << w;
    endfunction

    always @(posedge clk) begin : mdl
        int w;
        if (rst) begin
            m_ptr = 0; m_ov = 0; m_od = '0; m_os = 0; m_locked = 0; m_lid = 0;
        end else begin
            w = (!m_ov || out_ready) ? pick() : -1;
            if (w >= 0) begin
                m_ov = 1;
                m_od = req_data[w*W +: W];
                m_os = w;
                if (!m_locked) begin
                    if (req_lock[w]) begin
                        m_locked = 1;
                        m_lid = w;
                    end else m_ptr = (w + 1) % N;
                end else if (!req_lock[w]) begin
                    m_locked = 0;
                    m_ptr = (m_lid + 1) % N;
                end
            end else if (out_ready) m_ov = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_out_valid", out_valid, m_ov);
            chk("model_out_data", out_data, m_od);
            chk("model_out_src", out_src, m_os);
            chk("model_req_ready", req_ready, exp_ready());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int rot[5] = '{0, 1, 2, 3, 0};
        int wrap_seq[3] = '{3, 1, 3};
        for (int i = 0; i < N; i++) req_data[i*W +: W] = 32'hA000_0000 + i;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_src", out_src, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rot_src", out_src, rot[i]);
            chk("rot_data", out_data, 32'hA000_0000 + rot[i]);
        end
        do_reset();
        out_ready = 1'b0;
        step();
        chk("bp_first_src", out_src, 0);
        repeat (3) step();
        chk("bp_data_held", out_data, 32'hA000_0000);
        chk("bp_req_ready", req_ready, 0);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", req_ready, 4'b0010);
        step();
        chk("bp_next_src", out_src, 1);
        do_reset();
        req_valid = 4'b0010;
        step();
        chk("wrap_setup_src", out_src, 1);
        req_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wrap_src", out_src, wrap_seq[i]);
        end
        req_valid = 4'b0100;
        step();
        chk("drain_load_valid", out_valid, 1);
        chk("drain_load_src", out_src, 2);
        req_valid = 4'b0000;
        step();
        chk("drain_empty_valid", out_valid, 0);
`ifdef RESULT_ARB_LOCK_EN
        do_reset();
        req_valid = 4'b0001;
        step();
        chk("lock_setup_src", out_src, 0);
        req_valid = 4'b0111;
        req_lock = 4'b0010;
        step();
        chk("lock_grant1", out_src, 1);
        chk("lock_ready_holder", req_ready, 4'b0010);
        req_valid = 4'b0101;
        #1;
        chk("lock_idle_holder_ready", req_ready, 0);
        step();
        req_valid = 4'b0111;
        step();
        chk("lock_grant2", out_src, 1);
        req_lock = 4'b0000;
        step();
        chk("lock_grant3", out_src, 1);
        step();
        chk("lock_after_unlock", out_src, 2);
`endif
        req_valid = 4'b0000;
        step();
        step();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
